// File: rtl/apb_pkg.sv
// Shared APB definitions for the master and its completers: FSM state codes,
// master PMODE request codes and default bus widths.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 8;
  localparam int unsigned APB_DATA_WIDTH = 8;
  localparam int unsigned APB_PSEL_WIDTH = 2;
  localparam int unsigned WAIT_CTR_WIDTH = 4;

  // SETUP is only visited by the master; completers go IDLE -> ACCESS directly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  typedef enum logic [1:0] {
    PMODE_NOP   = 2'b00,
    PMODE_READ  = 2'b10,
    PMODE_WRITE = 2'b11
  } apb_pmode_e;

  function automatic logic pmode_is_write(apb_pmode_e mode);
    return mode == PMODE_WRITE;
  endfunction

endpackage

// File: rtl/apb_slave_wait_ctr.sv
// Loadable down-counter that paces wait states; holds at zero rather than wrapping.
module apb_slave_wait_ctr
  import apb_pkg::*;
(
  input  logic                      PCLK_i,
  input  logic                      PRESET_i,
  input  logic                      load,
  input  logic [WAIT_CTR_WIDTH-1:0] load_value,
  input  logic                      enable,
  output logic                      zero
);

  logic [WAIT_CTR_WIDTH-1:0] count_reg;

  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer serving NUM_REGS-1 RW registers plus a read-only count of OKAY transfers
// in the last slot; fixed wait states via PREADY_o, bad accesses answered with PSLVERR_o.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int unsigned PSEL_WIDTH  = APB_PSEL_WIDTH,
  parameter int unsigned PSEL_INDEX  = 0,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  PCLK_i,
  input  logic                  PRESET_i,
  input  logic [PSEL_WIDTH-1:0] PSEL_i,
  input  logic                  PENABLE_i,
  input  logic                  PWRITE_i,
  input  logic [ADDR_WIDTH-1:0] PADDR_i,
  input  logic [DATA_WIDTH-1:0] PWDATA_i,
  output logic [DATA_WIDTH-1:0] PRDATA_o,
  output logic                  PREADY_o,
  output logic                  PSLVERR_o,
  output logic [DATA_WIDTH-1:0] REG0_o
);

  localparam int unsigned             CNT_IDX    = NUM_REGS - 1;
  localparam logic [ADDR_WIDTH-1:0]   CNT_ADDR   = ADDR_WIDTH'(CNT_IDX);
  localparam logic [ADDR_WIDTH:0]     NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  apb_state_e            state_reg, state_next;
  logic                  sel, setup;
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] regs_reg [CNT_IDX];
  logic [DATA_WIDTH-1:0] xfer_cnt_reg;
  logic [DATA_WIDTH-1:0] rd_value;
  logic [CNT_IDX-1:0]    wr_en;
  logic                  ctr_load, ctr_en, wait_zero;
  logic                  complete, err, okay;

  assign sel   = PSEL_i[PSEL_INDEX];
  assign setup = sel && !PENABLE_i;

  // Errors are judged on the latched request so mid-ACCESS bus changes cannot alter them.
  assign err      = ({1'b0, addr_reg} >= NUM_REGS_W) || (write_reg && (addr_reg == CNT_ADDR));
  assign complete = (state_reg == ST_ACCESS) && sel && wait_zero;
  assign okay     = complete && !err;

  apb_slave_wait_ctr u_wait_ctr (
    .PCLK_i    (PCLK_i),
    .PRESET_i  (PRESET_i),
    .load      (ctr_load),
    .load_value(WAIT_CTR_WIDTH'(WAIT_CYCLES)),
    .enable    (ctr_en),
    .zero      (wait_zero)
  );

  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (setup) state_next = ST_ACCESS;
      ST_ACCESS: if (!sel || wait_zero) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    PREADY_o  = 1'b0;
    PSLVERR_o = 1'b0;
    PRDATA_o  = '0;
    case (state_reg)
      ST_IDLE: ctr_load = setup;
      ST_ACCESS: begin
        if (sel) begin
          ctr_en = PENABLE_i;
          if (wait_zero) begin
            PREADY_o  = 1'b1;
            PSLVERR_o = err;
            if (!write_reg && !err) PRDATA_o = rd_value;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if ((state_reg == ST_IDLE) && setup) begin
      write_reg <= PWRITE_i;
      addr_reg  <= PADDR_i;
      wdata_reg <= PWDATA_i;
    end
  end

  for (genvar gi = 0; gi < int'(CNT_IDX); gi++) begin : g_wr_dec
    assign wr_en[gi] = okay && write_reg && (addr_reg == ADDR_WIDTH'(gi));
  end

  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      for (int i = 0; i < int'(CNT_IDX); i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < int'(CNT_IDX); i++) begin
        if (wr_en[i]) regs_reg[i] <= wdata_reg;
      end
    end
  end

  // The counter slot falls out as the default when no RW register matches.
  always_comb begin
    rd_value = xfer_cnt_reg;
    for (int i = 0; i < int'(CNT_IDX); i++) begin
      if (addr_reg == ADDR_WIDTH'(i)) rd_value = regs_reg[i];
    end
  end

  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      xfer_cnt_reg <= '0;
    end else if (okay) begin
      xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
    end
  end

  assign REG0_o = regs_reg[0];

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Three completers (WAIT_CYCLES 1, 0, 3) driven by a bench-side APB master, checked every
// cycle against a transaction-level model plus literal expectations for the directed cases.
module tb_apb_slave_regbank;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] psel    [NDUT];
  logic       penable [NDUT];
  logic       pwrite  [NDUT];
  logic [7:0] paddr   [NDUT];
  logic [7:0] pwdata  [NDUT];
  logic [7:0] prdata  [NDUT];
  logic       pready  [NDUT];
  logic       pslverr [NDUT];
  logic [7:0] reg0    [NDUT];

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: register contents, OKAY counter, and the transfer in progress.
  int  mregs  [NDUT][16];
  int  mcnt   [NDUT];
  bit  mbusy  [NDUT];
  int  mwaited[NDUT];
  int  maddr  [NDUT];
  int  mdata  [NDUT];
  bit  mwrite [NDUT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    apb_slave_regbank #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .PSEL_WIDTH (2),
      .PSEL_INDEX (0),
      .NUM_REGS   (16),
      .WAIT_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
    ) u_dut (
      .PCLK_i   (clk),
      .PRESET_i (rst),
      .PSEL_i   (psel[gi]),
      .PENABLE_i(penable[gi]),
      .PWRITE_i (pwrite[gi]),
      .PADDR_i  (paddr[gi]),
      .PWDATA_i (pwdata[gi]),
      .PRDATA_o (prdata[gi]),
      .PREADY_o (pready[gi]),
      .PSLVERR_o(pslverr[gi]),
      .REG0_o   (reg0[gi])
    );
  end

  function automatic int wait_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic bit model_err(int d);
    return (maddr[d] >= 16) || (mwrite[d] && maddr[d] == 15);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int r = 0; r < 16; r++) mregs[d][r] = 0;
      mcnt[d] = 0; mbusy[d] = 0; mwaited[d] = 0;
      maddr[d] = 0; mdata[d] = 0; mwrite[d] = 0;
    end
  endtask

  // One clock of the protocol: a setup opens a transfer; it finishes after WAIT_CYCLES waits.
  task automatic model_step(int d);
    bit s;
    s = psel[d][0];
    if (!mbusy[d]) begin
      if (s && !penable[d]) begin
        mbusy[d] = 1; mwaited[d] = 0;
        maddr[d] = int'(paddr[d]); mdata[d] = int'(pwdata[d]); mwrite[d] = pwrite[d];
      end
    end else if (!s) begin
      mbusy[d] = 0;
    end else if (mwaited[d] == wait_of(d)) begin
      if (!model_err(d)) begin
        if (mwrite[d]) mregs[d][maddr[d]] = mdata[d];
        mcnt[d] = (mcnt[d] + 1) % 256;
      end
      mbusy[d] = 0;
    end else if (penable[d]) begin
      mwaited[d] = mwaited[d] + 1;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else for (int d = 0; d < NDUT; d++) model_step(d);
    end
  end

  // Compare process: every DUT output, every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        bit ready, e;
        int rd;
        ready = !rst && mbusy[d] && psel[d][0] && (mwaited[d] == wait_of(d));
        e = ready && model_err(d);
        rd = 0;
        if (ready && !mwrite[d] && !e) rd = (maddr[d] == 15) ? mcnt[d] : mregs[d][maddr[d]];
        chk($sformatf("dut%0d PREADY", d), int'(pready[d]), int'(ready));
        chk($sformatf("dut%0d PSLVERR", d), int'(pslverr[d]), int'(e));
        chk($sformatf("dut%0d PRDATA", d), int'(prdata[d]), rd);
        chk($sformatf("dut%0d REG0", d), int'(reg0[d]), mregs[d][0]);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] data,
                      output logic [7:0] rdata, output bit err, output int acc);
    bit done;
    @(posedge clk); #1;
    psel[d] = 2'b01; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    paddr[d] = 8'($urandom);
    pwdata[d] = 8'($urandom);
    acc = 0; rdata = '0; err = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      acc++;
      if (pready[d]) begin
        rdata = prdata[d]; err = pslverr[d]; done = 1;
      end
    end
    if (!done) chk($sformatf("dut%0d PREADY timeout", d), 0, 1);
    $display("dut%0d %s addr=%02h wdata=%02h rdata=%02h err=%0d access_cycles=%0d",
             d, wr ? "WR" : "RD", addr, data, rdata, err, acc);
  endtask

  task automatic idle(int d, int n);
    repeat (n) begin
      @(posedge clk); #1;
      psel[d] = 2'b00; penable[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin psel[d] = 2'b00; penable[d] = 1'b0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    bit         er;
    int         acc;

    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      psel[d] = 2'b00; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    end
    @(negedge clk);
    chk("reset PREADY", int'(pready[0]), 0);
    chk("reset REG0", int'(reg0[0]), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset while a write to reg 3 is in ACCESS: it must never land.
    @(posedge clk); #1;
    psel[0] = 2'b01; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h03; pwdata[0] = 8'hA5;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t1 PREADY in reset", int'(pready[0]), 0);
    chk("t1 PSLVERR in reset", int'(pslverr[0]), 0);
    chk("t1 PRDATA in reset", int'(prdata[0]), 0);
    psel[0] = 2'b00; penable[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    xfer(0, 0, 8'h03, 8'h00, rd, er, acc);
    chk("t1 reg3 after reset", int'(rd), 8'h00);

    // Basic write/read with one wait state, then the counter.
    do_reset();
    xfer(0, 1, 8'h02, 8'h5A, rd, er, acc);
    chk("t2 write access cycles", acc, 2);
    xfer(0, 0, 8'h02, 8'h00, rd, er, acc);
    chk("t2 read addr2", int'(rd), 8'h5A);
    chk("t2 read access cycles", acc, 2);
    xfer(0, 0, 8'h0F, 8'h00, rd, er, acc);
    chk("t2 counter", int'(rd), 2);

    // Error responses leave registers and counter alone.
    xfer(0, 0, 8'h20, 8'h00, rd, er, acc);
    chk("t3 out-of-range err", int'(er), 1);
    chk("t3 out-of-range rdata", int'(rd), 0);
    xfer(0, 1, 8'h0F, 8'h77, rd, er, acc);
    chk("t3 write counter err", int'(er), 1);
    xfer(0, 0, 8'h0F, 8'h00, rd, er, acc);
    chk("t3 counter unchanged", int'(rd), 3);
    chk("t3 counter read err", int'(er), 0);

    // Another slave's select, then an abort in the first ACCESS cycle.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      psel[0] = 2'b10; penable[0] = i[0]; pwrite[0] = 1'b1; paddr[0] = 8'h04; pwdata[0] = 8'h99;
      @(negedge clk);
      chk("t5 other-slave PREADY", int'(pready[0]), 0);
    end
    @(posedge clk); #1;
    psel[0] = 2'b01; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h04; pwdata[0] = 8'h77;
    @(posedge clk); #1;
    psel[0] = 2'b00;
    idle(0, 2);
    xfer(0, 0, 8'h04, 8'h00, rd, er, acc);
    chk("t5 aborted write", int'(rd), 0);

    // Back-to-back writes with 0 and 3 wait states.
    for (int d = 1; d < NDUT; d++) begin
      for (int a = 1; a <= 4; a++) begin
        xfer(d, 1, 8'(a), 8'(8'h10 * a + d), rd, er, acc);
        chk($sformatf("t4 dut%0d access cycles", d), acc, wait_of(d) + 1);
      end
      for (int a = 1; a <= 4; a++) begin
        xfer(d, 0, 8'(a), 8'h00, rd, er, acc);
        chk($sformatf("t4 dut%0d readback", d), int'(rd), 8'h10 * a + d);
      end
      idle(d, 1);
    end

    // Counter wrap and REG0 export timing.
    do_reset();
    for (int i = 0; i < 255; i++) xfer(0, 0, 8'h00, 8'h00, rd, er, acc);
    xfer(0, 0, 8'h0F, 8'h00, rd, er, acc);
    chk("t6 counter before wrap", int'(rd), 8'hFF);
    xfer(0, 0, 8'h0F, 8'h00, rd, er, acc);
    chk("t6 counter wrapped", int'(rd), 8'h00);
    xfer(0, 1, 8'h00, 8'h3C, rd, er, acc);
    chk("t6 REG0 at completion", int'(reg0[0]), 8'h00);
    idle(0, 1);
    @(negedge clk);
    chk("t6 REG0 after completion", int'(reg0[0]), 8'h3C);

    // Randomized traffic on all three completers.
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 120; n++) begin
        bit wr;
        wr = 1'($urandom_range(0, 1));
        xfer(d, wr, 8'($urandom_range(0, 19)), 8'($urandom), rd, er, acc);
        idle(d, $urandom_range(0, 2));
      end
      idle(d, 1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
